// File: rtl/mac_reg_slave.sv
// mac_reg_slave: register-side responder for the MAC configuration bus.
// Holds the MAC configuration registers (scratch, command, MAC address,
// FIFO thresholds, MDIO PHY address). It also forwards the PHY window
// 0x80-0x9F to an internal clause-22 MDIO master.
//   clk, rst_n                      clock / async active-low reset
//   reg_addr, reg_writedata         access address and write data
//   reg_rd, reg_wr                  level requests (write wins)
//   reg_readdata, reg_busy          read result / access in progress
//   cmd_config, mac_addr, fifo_thr  register contents to the MAC core
//   sw_reset                        timed MAC soft reset
//   mdc, mdio_out, mdio_oe, mdio_in MDIO pins
module mac_reg_slave #(
  parameter int unsigned REG_LAT      = 2,
  parameter int unsigned MDC_DIV      = 10,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   reg_addr,
  input  logic [31:0]  reg_writedata,
  input  logic         reg_rd,
  input  logic         reg_wr,
  output logic [31:0]  reg_readdata,
  output logic         reg_busy,
  output logic [31:0]  cmd_config,
  output logic [47:0]  mac_addr,
  output logic [127:0] fifo_thr,
  output logic         sw_reset,
  output logic         mdc,
  output logic         mdio_out,
  output logic         mdio_oe,
  input  logic         mdio_in
);

  typedef enum logic [1:0] {S_IDLE, S_REG, S_MDIO, S_GAP} state_e;

  state_e        state_q, state_d;
  logic          accept, reg_done, mdio_done;
  logic          busy_q, is_wr_q, sw_reset_q, mdc_q, mdio_out_q, mdio_oe_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q, rdata_q, scratch_q, cmd_q, mac0_q, rd_val;
  logic [31:0]   rst_cnt_q;
  logic [15:0]   lat_cnt_q, div_q, mac1_q, rx_q;
  logic [15:0]   thr_q [8];
  logic [4:0]    phy_q;
  logic [6:0]    bit_q;
  logic [62:0]   frame_q;  // bits 1..63 of the frame; bit 0 is driven at accept
  logic [2:0]    thr_idx;
  logic          in_thr;

  assign thr_idx = addr_q[2:0] - 3'd7;
  assign in_thr  = (addr_q >= 8'h07) && (addr_q <= 8'h0E);

  // bit13 of the command register mirrors the running soft reset
  assign cmd_config   = {cmd_q[31:14], sw_reset_q, cmd_q[12:0]};
  assign mac_addr     = {mac1_q, mac0_q};
  assign reg_busy     = busy_q;
  assign reg_readdata = rdata_q;
  assign sw_reset     = sw_reset_q;
  assign mdc          = mdc_q;
  assign mdio_out     = mdio_out_q;
  assign mdio_oe      = mdio_oe_q;

  always_comb begin
    fifo_thr = '0;
    for (int unsigned i = 0; i < 8; i++) fifo_thr[16*i +: 16] = thr_q[i];
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reg_done  = 1'b0;
    mdio_done = 1'b0;
    case (state_q)
      S_IDLE: if (reg_wr || reg_rd) begin
        accept  = 1'b1;
        state_d = (reg_addr[7:5] == 3'b100) ? S_MDIO : S_REG;
      end
      S_REG: if (lat_cnt_q == '0) begin
        reg_done = 1'b1;
        state_d  = S_GAP;
      end
      S_MDIO: if (bit_q == 7'd64) begin
        mdio_done = 1'b1;
        state_d   = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (addr_q)
      8'h01:   rd_val = scratch_q;
      8'h02:   rd_val = cmd_config;
      8'h03:   rd_val = mac0_q;
      8'h04:   rd_val = {16'h0, mac1_q};
      8'h0F:   rd_val = {27'h0, phy_q};
      default: if (in_thr) rd_val = {16'h0, thr_q[thr_idx]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0; is_wr_q <= 1'b0; addr_q <= '0; wdata_q <= '0;
      rdata_q <= '0; lat_cnt_q <= '0; scratch_q <= '0; cmd_q <= '0;
      mac0_q <= '0; mac1_q <= '0; phy_q <= '0;
      for (int unsigned i = 0; i < 8; i++) thr_q[i] <= '0;
      sw_reset_q <= 1'b0; rst_cnt_q <= '0;
      mdc_q <= 1'b0; mdio_out_q <= 1'b1; mdio_oe_q <= 1'b0;
      div_q <= '0; bit_q <= '0; frame_q <= '0; rx_q <= '0;
    end else begin
      if (accept) begin
        addr_q    <= reg_addr;
        wdata_q   <= reg_writedata;
        is_wr_q   <= reg_wr;
        busy_q    <= 1'b1;
        lat_cnt_q <= 16'(REG_LAT - 1);
        if (reg_addr[7:5] == 3'b100) begin
          frame_q    <= {31'h7FFF_FFFF, 2'b01, (reg_wr ? 2'b01 : 2'b10), phy_q,
                         reg_addr[4:0], (reg_wr ? 2'b10 : 2'b11),
                         (reg_wr ? reg_writedata[15:0] : 16'h0)};
          mdio_out_q <= 1'b1;
          mdio_oe_q  <= 1'b1;
          mdc_q      <= 1'b0;
          div_q      <= '0;
          bit_q      <= '0;
        end
      end

      if (state_q == S_REG && lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - 16'd1;

      if (reg_done || mdio_done) busy_q <= 1'b0;
      if (reg_done && !is_wr_q)  rdata_q <= rd_val;
      if (mdio_done && !is_wr_q) rdata_q <= {16'h0, rx_q};

      if (sw_reset_q) begin
        if (rst_cnt_q == '0) sw_reset_q <= 1'b0;
        else                 rst_cnt_q  <= rst_cnt_q - 32'd1;
      end

      if (reg_done && is_wr_q) begin
        case (addr_q)
          8'h01: scratch_q <= wdata_q;
          8'h02: begin
            cmd_q <= wdata_q & ~32'h0000_2000;
            // a bit13 write (re)starts the window; the plain-write path above
            // is overridden here so a restart always wins
            if (wdata_q[13]) begin
              sw_reset_q <= 1'b1;
              rst_cnt_q  <= 32'(RESET_CYCLES - 1);
            end
          end
          8'h03:   mac0_q <= wdata_q;
          8'h04:   mac1_q <= wdata_q[15:0];
          8'h0F:   phy_q  <= wdata_q[4:0];
          default: if (in_thr) thr_q[thr_idx] <= wdata_q[15:0];
        endcase
      end

      if (state_q == S_MDIO && bit_q != 7'd64) begin
        if (div_q == 16'(MDC_DIV - 1)) begin
          div_q <= '0;
          mdc_q <= ~mdc_q;
          if (!mdc_q) begin
            if (!is_wr_q && bit_q >= 7'd48) rx_q <= {rx_q[14:0], mdio_in};
          end else begin
            bit_q   <= bit_q + 7'd1;
            frame_q <= frame_q << 1;
            if (bit_q == 7'd63) begin
              mdio_out_q <= 1'b1;
              mdio_oe_q  <= 1'b0;
            end else begin
              mdio_out_q <= frame_q[62];
              // release the line from the second turnaround bit on a read
              if (!is_wr_q && bit_q >= 7'd46) mdio_oe_q <= 1'b0;
            end
          end
        end else begin
          div_q <= div_q + 16'd1;
        end
      end
    end
  end

endmodule
